// File: rtl/m68k_arb_pkg.sv
// Shared definitions for the 68K bus arbiter: state encoding and default timing parameters.
// Also used by the cycle engine and the debug status register.
package m68k_arb_pkg;

    typedef enum logic [2:0] {
        ST_OWN   = 3'd0,
        ST_PEND  = 3'd1,
        ST_GRANT = 3'd2,
        ST_EXT   = 3'd3,
        ST_REL   = 3'd4
    } arb_state_t;

    localparam int DEF_SYNC_STAGES = 2;
    localparam int DEF_BG_TIMEOUT  = 16;
    localparam int DEF_REARB_GAP   = 2;

endpackage

// File: rtl/m68k_bus_arbiter_sync_ff.sv
// Multi-stage synchroniser for an asynchronous active-low bus line.
// All stages reset to RESET_VAL so a line reads as negated until it has really been sampled.
module sync_ff #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b1
) (
    input  logic c8m,
    input  logic s0rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    always_ff @(posedge c8m or posedge s0rst) begin
        if (s0rst) begin
            chain <= {STAGES{RESET_VAL}};
        end else begin
            chain <= {chain[STAGES-2:0], d};
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/m68k_bus_arbiter.sv
// Bus-ownership controller between the Pi-driven cycle engine and external BR/BG/BGACK masters.
// Outputs are registered and decoded from the next state so they change on the same edge as the state.
module m68k_bus_arbiter
    import m68k_arb_pkg::*;
#(
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int BG_TIMEOUT  = DEF_BG_TIMEOUT,
    parameter int REARB_GAP   = DEF_REARB_GAP
) (
    input  logic       c8m,
    input  logic       s0rst,
    input  logic       br_n,
    input  logic       bgack_n,
    input  logic       as_int,
    input  logic       cyc_idle,
    input  logic       pi_req,
    output logic       bg_n,
    output logic       cyc_start_en,
    output logic       drive_en,
    output logic       ext_owner,
    output logic       timeout_evt,
    output logic [2:0] arb_state
);

    localparam int TW = $clog2(BG_TIMEOUT + 1);
    localparam int GW = $clog2(REARB_GAP + 1);

    logic br_s;
    logic bgack_s;

    arb_state_t    state;
    arb_state_t    state_nxt;
    logic          tmo_hit;
    logic          rel_done;
    logic [TW-1:0] tmo_cnt;
    logic [GW-1:0] gap_cnt;
    logic          fair;
    logic          pi_busy_seen;

    sync_ff #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_br (
        .c8m   (c8m),
        .s0rst (s0rst),
        .d     (br_n),
        .q     (br_s)
    );

    sync_ff #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_bgack (
        .c8m   (c8m),
        .s0rst (s0rst),
        .d     (bgack_n),
        .q     (bgack_s)
    );

    // In GRANT an acknowledge beats a withdrawn request, which beats the timeout.
    always_comb begin
        state_nxt = state;
        tmo_hit   = 1'b0;
        rel_done  = 1'b0;
        case (state)
            ST_OWN: begin
                if (!br_s && !fair) state_nxt = ST_PEND;
            end
            ST_PEND: begin
                if (br_s)                     state_nxt = ST_OWN;
                else if (cyc_idle && as_int)  state_nxt = ST_GRANT;
            end
            ST_GRANT: begin
                if (!bgack_s) begin
                    state_nxt = ST_EXT;
                end else if (br_s) begin
                    state_nxt = ST_OWN;
                end else if (tmo_cnt == TW'(BG_TIMEOUT - 1)) begin
                    state_nxt = ST_OWN;
                    tmo_hit   = 1'b1;
                end
            end
            ST_EXT: begin
                if (bgack_s) state_nxt = ST_REL;
            end
            ST_REL: begin
                if (gap_cnt == GW'(REARB_GAP - 1)) begin
                    state_nxt = ST_OWN;
                    rel_done  = 1'b1;
                end
            end
            default: state_nxt = ST_OWN;
        endcase
    end

    // fair holds off BR after an external tenure until the Pi gets one full cycle (idle 1->0->1).
    always_ff @(posedge c8m or posedge s0rst) begin
        if (s0rst) begin
            state        <= ST_OWN;
            bg_n         <= 1'b1;
            cyc_start_en <= 1'b1;
            drive_en     <= 1'b1;
            ext_owner    <= 1'b0;
            timeout_evt  <= 1'b0;
            tmo_cnt      <= '0;
            gap_cnt      <= '0;
            fair         <= 1'b0;
            pi_busy_seen <= 1'b0;
        end else begin
            state        <= state_nxt;
            bg_n         <= (state_nxt != ST_GRANT);
            cyc_start_en <= (state_nxt == ST_OWN);
            drive_en     <= (state_nxt inside {ST_OWN, ST_PEND, ST_GRANT});
            ext_owner    <= (state_nxt == ST_EXT);
            timeout_evt  <= tmo_hit;
            tmo_cnt      <= (state == ST_GRANT && state_nxt == ST_GRANT) ? tmo_cnt + 1'b1 : '0;
            gap_cnt      <= (state == ST_REL && state_nxt == ST_REL) ? gap_cnt + 1'b1 : '0;
            if (rel_done) begin
                fair         <= pi_req;
                pi_busy_seen <= 1'b0;
            end else if (fair) begin
                if (!cyc_idle) begin
                    pi_busy_seen <= 1'b1;
                end else if (pi_busy_seen || !pi_req) begin
                    fair         <= 1'b0;
                    pi_busy_seen <= 1'b0;
                end
            end
        end
    end

    assign arb_state = state;

endmodule

// File: tb/tb_m68k_bus_arbiter.sv
// Scoreboard bench for m68k_bus_arbiter: a behavioural ownership model predicts every cycle's outputs.
// The driver pushes predictions at the falling edge; a monitor pops and compares after each rising edge.
module tb_m68k_bus_arbiter;

    localparam int SYNC = 2;
    localparam int TMO  = 16;
    localparam int GAP  = 2;

    localparam int M_OWN   = 0;
    localparam int M_PEND  = 1;
    localparam int M_GRANT = 2;
    localparam int M_EXT   = 3;
    localparam int M_REL   = 4;

    logic       c8m = 1'b0;
    logic       s0rst = 1'b0;
    logic       br_n = 1'b1;
    logic       bgack_n = 1'b1;
    logic       as_int = 1'b1;
    logic       cyc_idle = 1'b1;
    logic       pi_req = 1'b0;
    logic       bg_n;
    logic       cyc_start_en;
    logic       drive_en;
    logic       ext_owner;
    logic       timeout_evt;
    logic [2:0] arb_state;

    m68k_bus_arbiter #(
        .SYNC_STAGES (SYNC),
        .BG_TIMEOUT  (TMO),
        .REARB_GAP   (GAP)
    ) dut (
        .c8m          (c8m),
        .s0rst        (s0rst),
        .br_n         (br_n),
        .bgack_n      (bgack_n),
        .as_int       (as_int),
        .cyc_idle     (cyc_idle),
        .pi_req       (pi_req),
        .bg_n         (bg_n),
        .cyc_start_en (cyc_start_en),
        .drive_en     (drive_en),
        .ext_owner    (ext_owner),
        .timeout_evt  (timeout_evt),
        .arb_state    (arb_state)
    );

    always #5 c8m = ~c8m;

    int total = 0;
    int bad = 0;
    logic [7:0] exp_q[$];

    // Reference model: who owns the bus, how long we have waited, and the Pi fairness debt.
    int mode;
    int grant_clocks;
    int rel_clocks;
    bit fair;
    bit pi_busy;
    bit br_pipe[$];
    bit bgack_pipe[$];

    function automatic logic [7:0] expect_out(int m, bit tmo);
        logic [2:0] st;
        st = 3'(m);
        return {m != M_GRANT, m == M_OWN, m <= M_GRANT, m == M_EXT, tmo, st};
    endfunction

    function automatic void model_reset();
        mode = M_OWN;
        grant_clocks = 0;
        rel_clocks = 0;
        fair = 1'b0;
        pi_busy = 1'b0;
        br_pipe.delete();
        bgack_pipe.delete();
        for (int i = 0; i < SYNC; i++) begin
            br_pipe.push_back(1'b1);
            bgack_pipe.push_back(1'b1);
        end
    endfunction

    function automatic logic [7:0] model_step(bit br_raw, bit bgack_raw, bit as_v, bit idle_v, bit pi_v);
        bit br_seen;
        bit bgack_seen;
        bit tmo;
        bit gap_over;
        int nxt;
        br_seen = br_pipe.pop_front();
        bgack_seen = bgack_pipe.pop_front();
        br_pipe.push_back(br_raw);
        bgack_pipe.push_back(bgack_raw);
        tmo = 1'b0;
        gap_over = 1'b0;
        nxt = mode;
        if (mode == M_OWN) begin
            if (!br_seen && !fair) nxt = M_PEND;
        end else if (mode == M_PEND) begin
            if (br_seen) nxt = M_OWN;
            else if (idle_v && as_v) nxt = M_GRANT;
        end else if (mode == M_GRANT) begin
            grant_clocks++;
            if (!bgack_seen) nxt = M_EXT;
            else if (br_seen) nxt = M_OWN;
            else if (grant_clocks == TMO) begin
                nxt = M_OWN;
                tmo = 1'b1;
            end
        end else if (mode == M_EXT) begin
            if (bgack_seen) nxt = M_REL;
        end else begin
            rel_clocks++;
            if (rel_clocks == GAP) begin
                nxt = M_OWN;
                gap_over = 1'b1;
            end
        end
        if (gap_over) begin
            fair = pi_v;
            pi_busy = 1'b0;
        end else if (fair) begin
            if (!idle_v) pi_busy = 1'b1;
            else if (pi_busy || !pi_v) begin
                fair = 1'b0;
                pi_busy = 1'b0;
            end
        end
        if (nxt == M_GRANT && mode != M_GRANT) grant_clocks = 0;
        if (nxt == M_REL && mode != M_REL) rel_clocks = 0;
        mode = nxt;
        return expect_out(mode, tmo);
    endfunction

    task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s at %0t: {bg_n,cse,drv,ext,tmo,state} got %b want %b", name, $time, act, exp);
        end
    endtask

    task automatic applyStimulus(input bit br_v, input bit bgack_v, input bit as_v, input bit idle_v, input bit pi_v);
        br_n = br_v;
        bgack_n = bgack_v;
        as_int = as_v;
        cyc_idle = idle_v;
        pi_req = pi_v;
        exp_q.push_back(model_step(br_v, bgack_v, as_v, idle_v, pi_v));
        @(negedge c8m);
    endtask

    // Monitor: one prediction per rising edge outside reset.
    initial begin
        logic [7:0] want;
        forever begin
            @(posedge c8m);
            #1;
            if (!s0rst && exp_q.size() > 0) begin
                want = exp_q.pop_front();
                checkOutput("cycle", {bg_n, cyc_start_en, drive_en, ext_owner, timeout_evt, arb_state}, want);
            end
        end
    end

    initial begin
        bit br_r;
        bit bgack_r;
        bit idle_r;
        bit as_r;
        bit pi_r;
        model_reset();
        #1 s0rst = 1'b1;
        #2 checkOutput("reset", {bg_n, cyc_start_en, drive_en, ext_owner, timeout_evt, arb_state}, expect_out(M_OWN, 1'b0));
        @(negedge c8m);
        s0rst = 1'b0;

        // Idle grant, external tenure, release with Pi pending and BR still low.
        repeat (6) applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        repeat (6) applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        repeat (8) applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
        repeat (3) applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        // Pi cycle done: fairness lapses, regrant, then BGACK never comes and the grant times out.
        repeat (26) applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);

        // Request withdrawn while a cycle is in flight.
        repeat (5) applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        repeat (5) applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        repeat (6) applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);

        // Request mid-cycle, bus goes idle later.
        repeat (10) applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        repeat (4) applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);

        // Reach EXT and hit reset mid-tenure.
        repeat (8) applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        @(posedge c8m);
        #2 s0rst = 1'b1;
        #1 checkOutput("reset_in_ext", {bg_n, cyc_start_en, drive_en, ext_owner, timeout_evt, arb_state}, expect_out(M_OWN, 1'b0));
        model_reset();
        @(negedge c8m);
        s0rst = 1'b0;
        repeat (4) applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);

        // Randomised traffic with sticky inputs so states persist for a while.
        br_r = 1'b1;
        bgack_r = 1'b1;
        idle_r = 1'b1;
        pi_r = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 9) == 0) br_r = ~br_r;
            if ($urandom_range(0, 7) == 0) bgack_r = ~bgack_r;
            if ($urandom_range(0, 3) == 0) idle_r = ~idle_r;
            if ($urandom_range(0, 5) == 0) pi_r = ~pi_r;
            as_r = idle_r ? ($urandom_range(0, 4) != 0) : 1'($urandom_range(0, 1));
            applyStimulus(br_r, bgack_r, as_r, idle_r, pi_r);
        end

        repeat (4) @(posedge c8m);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("[TB] FAIL drain: %0d predictions left, want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
